// File: rtl/uart_tx_frame_if.sv
// Handshake/serial bundle for uart_tx_frame: request level and data in, serial line and status out.
interface uart_tx_frame_if;
  logic       send;
  logic [7:0] din;
  logic       tx_out;
  logic       busy;
  logic       tx_done;

  modport master (output send, din, input tx_out, busy, tx_done);
  modport slave  (input send, din, output tx_out, busy, tx_done);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: one 8-bit asynchronous UART frame per rising edge of the debounced send level.
// Define UART_TX_PARITY_EN to insert an odd-parity bit before the stop bit (8O1 instead of 8N1).
module uart_tx_frame #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 19_200
) (
  input logic            clk,
  input logic            reset,
  uart_tx_frame_if.slave bus
);

  localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int unsigned TW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          send_q;
  logic          send_edge;
  logic          bit_end;
  logic          line;
  logic          done_d;
  logic          tx_q, busy_q, done_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // send_q resets high so a level already asserted at reset release is not an edge.
  assign send_edge = bus.send & ~send_q;
  assign bit_end   = (timer == BIT_LAST);

  always_comb begin
    state_d = state;
    timer_d = timer;
    idx_d   = idx;
    shift_d = shift;
    done_d  = 1'b0;
    line    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state != IDLE) begin
      timer_d = bit_end ? '0 : timer + 1'b1;
    end
    case (state)
      IDLE: begin
        if (send_edge) begin
          state_d = START;
          shift_d = bus.din;
          timer_d = '0;
          idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ~^bus.din;
`endif
        end
      end
      START: begin
        line = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        line = shift[0];
        if (bit_end) begin
          shift_d = shift >> 1;
          idx_d   = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line = par_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        line = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the line lags the FSM by one cycle
  // and tx_done lands in the last registered cycle of the stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      timer  <= '0;
      idx    <= '0;
      shift  <= '0;
      send_q <= 1'b1;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      timer  <= timer_d;
      idx    <= idx_d;
      shift  <= shift_d;
      send_q <= bus.send;
      tx_q   <= line;
      busy_q <= (state != IDLE);
      done_q <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  assign bus.tx_out  = tx_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame at CLK_FREQ=1000, BAUD_RATE=100 (10 cycles per bit); honours UART_TX_PARITY_EN.
module tb_uart_tx_frame;

  localparam int unsigned BC = 10;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int FL = NBITS * BC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  uart_tx_frame_if bus ();

  uart_tx_frame #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model: a frame is a list of line bits; 'since' counts clock edges since the accepting edge.
  logic [2:0] exp_out = 3'b100;  // {tx_out, busy, tx_done}

  initial begin : model
    int         since;
    logic       send_prev;
    logic       edge_seen;
    logic [10:0] fb;
    int         k;
    since     = FL + 1;
    send_prev = 1'b1;
    fb        = '1;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        since     = FL + 1;
        send_prev = 1'b1;
        exp_out   = 3'b100;
      end else begin
        edge_seen = bus.send && !send_prev;
        send_prev = bus.send;
        if (since <= FL) since++;
        if (edge_seen && since > FL) begin
          since    = 0;
          fb       = '1;
          fb[0]    = 1'b0;
          fb[8:1]  = bus.din;
`ifdef UART_TX_PARITY_EN
          fb[9]    = ~^bus.din;
`endif
        end
        k = since - 1;
        if (k >= 0 && k < FL)
          exp_out = {fb[k / BC], 1'b1, (k == FL - 1)};
        else
          exp_out = 3'b100;
      end
    end
  end

  always @(negedge clk) begin
    compared++;
    if ({bus.tx_out, bus.busy, bus.tx_done} !== exp_out) begin
      mismatched++;
      $display("FAIL line cycle %0d: tx/busy/done got %b required %b",
               cyc, {bus.tx_out, bus.busy, bus.tx_done}, exp_out);
    end
  end

  task automatic check(input string nm, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  // Called right after send is raised; measures latency, captures mid-bit line values.
  task automatic run_frame(input string nm, input logic [10:0] lit);
    int          lat  = 0;
    int          blen = 0;
    int          dcnt = 0;
    int          dpos = 0;
    logic [10:0] got  = '0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.busy && lat < 50);
    while (bus.busy && blen < 200) begin
      if (blen % BC == BC / 2) got[blen / BC] = bus.tx_out;
      if (bus.tx_done) begin
        dcnt++;
        dpos = blen + 1;
      end
      blen++;
      @(negedge clk);
    end
    check({nm, " latency"}, lat, 2);
    check({nm, " bits"}, int'(got), int'(lit));
    check({nm, " busy_len"}, blen, FL);
    check({nm, " done_cnt"}, dcnt, 1);
    check({nm, " done_pos"}, dpos, FL);
  endtask

  task automatic raise(input logic [7:0] d);
    bus.send = 1'b0;
    @(negedge clk);
    bus.din  = d;
    bus.send = 1'b1;
  endtask

  task automatic idle_window(input string nm, input int n);
    int b = 0;
    int z = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.busy) b++;
      if (!bus.tx_out) z++;
    end
    check({nm, " busy_cycles"}, b, 0);
    check({nm, " low_cycles"}, z, 0);
  endtask

  initial begin : stim
    int n;
    bus.send = 1'b0;
    bus.din  = '0;
    reset    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx_out", int'(bus.tx_out), 1);
    check("reset busy", int'(bus.busy), 0);
    check("reset tx_done", int'(bus.tx_done), 0);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1/2: basic frame (parity variant when enabled)
    raise(8'hA5);
`ifdef UART_TX_PARITY_EN
    run_frame("A5", 11'h74A);
`else
    run_frame("A5", 11'h34A);
`endif
    raise(8'h07);
`ifdef UART_TX_PARITY_EN
    run_frame("07", 11'h40E);
`else
    run_frame("07", 11'h20E);
`endif

    // 3: held send gives exactly one frame
    raise(8'h41);
`ifdef UART_TX_PARITY_EN
    run_frame("41", 11'h682);
`else
    run_frame("41", 11'h282);
`endif
    idle_window("hold", 200);
    raise(8'h41);
`ifdef UART_TX_PARITY_EN
    run_frame("41 again", 11'h682);
`else
    run_frame("41 again", 11'h282);
`endif

    // 4: edge and din change while busy are ignored
    raise(8'h00);
    fork
`ifdef UART_TX_PARITY_EN
      run_frame("00", 11'h600);
`else
      run_frame("00", 11'h200);
`endif
      begin
        repeat (30) @(negedge clk);
        bus.din  = 8'hFF;
        bus.send = 1'b0;
        @(negedge clk);
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
      end
    join

    // 5: reset mid-frame
    raise(8'h3C);
    repeat (45) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset tx_out", int'(bus.tx_out), 1);
    check("midreset busy", int'(bus.busy), 0);
    check("midreset tx_done", int'(bus.tx_done), 0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    idle_window("after reset", 150);
    raise(8'h5A);
`ifdef UART_TX_PARITY_EN
    run_frame("5A", 11'h6B4);
`else
    run_frame("5A", 11'h2B4);
`endif

    // 6: new edge in the tx_done cycle, minimum one idle cycle after the stop bit
    raise(8'hC3);
    @(negedge clk);
    bus.send = 1'b0;
    n = 0;
    while (!bus.tx_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_done seen", int'(bus.tx_done), 1);
    bus.din  = 8'h5A;
    bus.send = 1'b1;
`ifdef UART_TX_PARITY_EN
    run_frame("b2b 5A", 11'h6B4);
`else
    run_frame("b2b 5A", 11'h2B4);
`endif
    bus.send = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
